// File: rtl/alu_arbiter.sv
// Round-robin arbiter between the integer execute port and the branch/address port,
// feeding one shared ALU whose result lands in a single registered response buffer.
module alu_arbiter #(
    parameter int OP_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OP_W-1:0] req0_op,
    input  logic [31:0]     req0_src1,
    input  logic [31:0]     req0_src2,
    input  logic [31:0]     req0_imm_s,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OP_W-1:0] req1_op,
    input  logic [31:0]     req1_src1,
    input  logic [31:0]     req1_src2,
    input  logic [31:0]     req1_imm_s,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [31:0]     rsp_data,
    output logic            rsp_cond
);
    localparam int DATA_W = 32;

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SLTU = OP_W'(9);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_BLT  = OP_W'(12);
    localparam logic [OP_W-1:0] OP_BGE  = OP_W'(13);
    localparam logic [OP_W-1:0] OP_BLTU = OP_W'(14);
    localparam logic [OP_W-1:0] OP_BGEU = OP_W'(15);
    localparam logic [OP_W-1:0] OP_ADDS = OP_W'(16);

    // Returns {cond, data}; reserved codes fall through to all zeros.
    function automatic logic [DATA_W:0] alu_eval(
        input logic [OP_W-1:0]          op,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b,
        input logic signed [DATA_W-1:0] imm
    );
        logic [4:0]        sh;
        logic              c;
        logic [DATA_W-1:0] r;
        sh = b[4:0];
        c  = 1'b0;
        r  = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << sh;
            OP_SRL:  r = $unsigned(a) >> sh;
            OP_SRA:  r = a >>> sh;
            OP_SLT:  r = {{(DATA_W-1){1'b0}}, (a < b)};
            OP_SLTU: r = {{(DATA_W-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
            OP_BEQ:  c = (a == b);
            OP_BNE:  c = (a != b);
            OP_BLT:  c = (a < b);
            OP_BGE:  c = (a >= b);
            OP_BLTU: c = ($unsigned(a) < $unsigned(b));
            OP_BGEU: c = ($unsigned(a) >= $unsigned(b));
            OP_ADDS: r = imm + a;
            default: r = '0;
        endcase
        // Branch results mirror the condition in bit 0; c is only ever set by branches.
        if (c) r = DATA_W'(1);
        return {c, r};
    endfunction

    logic prio;
    logic grant0, grant1, slot_free, accept;

    logic [OP_W-1:0]          op_p0;
    logic signed [DATA_W-1:0] src1_p0, src2_p0, imm_p0;
    logic [DATA_W:0]          alu_p0;

    logic              vld_p1, id_p1, cond_p1;
    logic [DATA_W-1:0] data_p1;

    // Stage p0: grant, handshake and combinational ALU on the granted payload
    always_comb begin
        grant0 = req0_valid & (~req1_valid | ~prio);
        grant1 = req1_valid & (~req0_valid | prio);
    end

    assign slot_free  = (~vld_p1 | rsp_ready) & ~rst;
    assign req0_ready = grant0 & slot_free;
    assign req1_ready = grant1 & slot_free;
    assign accept     = req0_ready | req1_ready;

    assign op_p0   = grant1 ? req1_op    : req0_op;
    assign src1_p0 = grant1 ? req1_src1  : req0_src1;
    assign src2_p0 = grant1 ? req1_src2  : req0_src2;
    assign imm_p0  = grant1 ? req1_imm_s : req0_imm_s;
    assign alu_p0  = alu_eval(op_p0, src1_p0, src2_p0, imm_p0);

    // Stage p1: response buffer and priority pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            id_p1   <= 1'b0;
            data_p1 <= '0;
            cond_p1 <= 1'b0;
            prio    <= 1'b0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            id_p1   <= grant1;
            data_p1 <= alu_p0[DATA_W-1:0];
            cond_p1 <= alu_p0[DATA_W];
            prio    <= ~grant1;
        end else if (rsp_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_id    = id_p1;
    assign rsp_data  = data_p1;
    assign rsp_cond  = cond_p1;
endmodule
